// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the debug memory dumper.
// Build option: define DUMP_CHECKSUM_EN to append an XOR checksum byte to the dump.
package mem_dump_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int BITS_BYTE_DEFAULT = 8;
  localparam int CHECKSUM_WIDTH    = 8;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_CHK,
    ST_DONE
  } dump_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_DONE
  } dump_state_t;
`endif

endpackage

// File: rtl/dump_byte_serializer.sv
// Holds one memory word and hands it out a byte at a time, low byte first.
// Flags when the byte currently presented is the last one of the word.
module dump_byte_serializer
  import mem_dump_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int BITS_BYTE = BITS_BYTE_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [BITS_SIZE-1:0] i_word,
  input  logic                 i_advance,
  output logic [BITS_BYTE-1:0] o_byte,
  output logic                 o_last
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [BITS_SIZE-1:0] word_sr;
  logic [IDX_W-1:0]     byte_idx;

  // Capture a new word or shift the next byte down into the low lane.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_sr  <= '0;
      byte_idx <= '0;
    end else if (i_clear) begin
      byte_idx <= '0;
    end else if (i_load) begin
      word_sr  <= i_word;
      byte_idx <= '0;
    end else if (i_advance) begin
      word_sr  <= word_sr >> BITS_BYTE;
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  assign o_byte = word_sr[BITS_BYTE-1:0];
  assign o_last = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/debug_mem_dumper.sv
// Walks the data memory through its debug read port and streams every word
// to the debug UART transmitter as four bytes, least-significant first.
// Build option: define DUMP_CHECKSUM_EN to send a trailing XOR checksum byte.
module debug_mem_dumper
  import mem_dump_pkg::*;
#(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 16,
  parameter int BITS_BYTE     = BITS_BYTE_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [BITS_SIZE-1:0] o_debug_address,
  input  logic [BITS_SIZE-1:0] i_debug_data,
  output logic [BITS_BYTE-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int ADDR_W = (SIZE_MEM_DATA > 1) ? $clog2(SIZE_MEM_DATA) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE_MEM_DATA - 1);

  dump_state_t          state;
  dump_state_t          next_state;
  logic [ADDR_W-1:0]    addr;
  logic [BITS_BYTE-1:0] tx_data_q;
  logic [BITS_BYTE-1:0] ser_byte;
  logic                 ser_last;
  logic                 ser_clear;
  logic                 ser_load;
  logic                 ser_advance;
  logic                 addr_clear;
  logic                 addr_inc;

`ifdef DUMP_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] checksum;
  logic                      chk_phase;
  logic                      chk_enter;
`endif

  dump_byte_serializer #(
    .BITS_SIZE (BITS_SIZE),
    .BITS_BYTE (BITS_BYTE)
  ) u_serializer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (ser_clear),
    .i_load    (ser_load),
    .i_word    (i_debug_data),
    .i_advance (ser_advance),
    .o_byte    (ser_byte),
    .o_last    (ser_last)
  );

  assign o_debug_address = BITS_SIZE'(addr);

  // State register plus the word address counter and the held TX byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      tx_data_q <= '0;
    end else begin
      state <= next_state;
      if (addr_clear) begin
        addr <= '0;
      end else if (addr_inc) begin
        addr <= addr + ADDR_W'(1);
      end
      if (o_tx_start) begin
        tx_data_q <= o_tx_data;
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running XOR of every data byte strobed out, and a flag for the checksum pass.
  always_ff @(posedge i_clk) begin
    if (i_reset || addr_clear) begin
      checksum  <= '0;
      chk_phase <= 1'b0;
    end else begin
      if (state == ST_SEND) begin
        checksum <= checksum ^ CHECKSUM_WIDTH'(ser_byte);
      end
      if (chk_enter) begin
        chk_phase <= 1'b1;
      end
    end
  end
`endif

  // Next-state logic and the TX handshake outputs.
  always_comb begin
    next_state  = state;
    ser_clear   = 1'b0;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    addr_clear  = 1'b0;
    addr_inc    = 1'b0;
    o_tx_start  = 1'b0;
    o_tx_data   = tx_data_q;
    o_busy      = (state != ST_IDLE);
    o_done      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    chk_enter   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          addr_clear = 1'b1;
          ser_clear  = 1'b1;
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ser_load   = 1'b1;
        next_state = ST_SEND;
      end
      ST_SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = ser_byte;
        next_state = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
          if (chk_phase) begin
            next_state = ST_DONE;
          end else if (!ser_last) begin
            ser_advance = 1'b1;
            next_state  = ST_SEND;
          end else if (addr != LAST_ADDR) begin
            addr_inc   = 1'b1;
            next_state = ST_LOAD;
          end else begin
            next_state = ST_CHK;
          end
`else
          if (!ser_last) begin
            ser_advance = 1'b1;
            next_state  = ST_SEND;
          end else if (addr != LAST_ADDR) begin
            addr_inc   = 1'b1;
            next_state = ST_LOAD;
          end else begin
            next_state = ST_DONE;
          end
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CHK: begin
        o_tx_start = 1'b1;
        o_tx_data  = BITS_BYTE'(checksum);
        chk_enter  = 1'b1;
        next_state = ST_WAIT_TX;
      end
`endif
      ST_DONE: begin
        o_done     = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Self-checking bench for debug_mem_dumper: a memory array, a UART TX responder
// and an expected byte stream built from the memory contents.
// Honours DUMP_CHECKSUM_EN to expect the trailing checksum byte.
module tb_debug_mem_dumper;

  localparam int BITS_SIZE     = 32;
  localparam int SIZE_MEM_DATA = 16;
  localparam int BITS_BYTE     = 8;
  localparam int DATA_BYTES    = 4 * SIZE_MEM_DATA;
`ifdef DUMP_CHECKSUM_EN
  localparam int TOTAL_BYTES   = DATA_BYTES + 1;
`else
  localparam int TOTAL_BYTES   = DATA_BYTES;
`endif

  typedef struct {
    int         pattern;
    int         gap;
    bit         holdStart;
    bit         spurious;
    int         probeIdx;
    logic [7:0] probeByte;
  } scen_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 tx_done;
  logic [BITS_SIZE-1:0] debug_address;
  logic [BITS_SIZE-1:0] debug_data;
  logic [BITS_BYTE-1:0] tx_data;
  logic                 tx_start;
  logic                 busy;
  logic                 done;
  logic [31:0]          mem [SIZE_MEM_DATA];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  debug_mem_dumper #(
    .BITS_SIZE     (BITS_SIZE),
    .SIZE_MEM_DATA (SIZE_MEM_DATA),
    .BITS_BYTE     (BITS_BYTE)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_start         (start),
    .o_debug_address (debug_address),
    .i_debug_data    (debug_data),
    .o_tx_data       (tx_data),
    .o_tx_start      (tx_start),
    .i_tx_done       (tx_done),
    .o_busy          (busy),
    .o_done          (done)
  );

  assign debug_data = mem[debug_address[3:0]];

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fillMem(input int pattern);
    for (int i = 0; i < SIZE_MEM_DATA; i++) begin
      case (pattern)
        0:       mem[i] = 32'(i);
        1:       mem[i] = 32'(i + 1);
        default: mem[i] = $urandom;
      endcase
    end
    if (pattern == 0) mem[2] = 32'hDEADBEEF;
    if (pattern == 2) mem[0] = 32'h11223344;
  endtask

  // Runs one dump; abortAt >= 0 asserts reset while waiting on that byte index.
  task automatic applyStimulus(input scen_t s, input int abortAt);
    logic [7:0]  expq[$];
    logic [7:0]  cks;
    logic [31:0] word;
    logic [31:0] prevAddr;
    int          sent;
    int          countdown;
    int          lastDone;
    int          startCyc;
    int          limit;
    bit          seenDone;
    bit          aborted;

    cks = 8'h00;
    for (int w = 0; w < SIZE_MEM_DATA; w++) begin
      word = mem[w];
      for (int b = 0; b < 4; b++) begin
        expq.push_back(word[8*b +: 8]);
        cks = cks ^ word[8*b +: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    expq.push_back(cks);
`endif

    startCyc = cyc;
    start    = 1'b1;
    tx_done  = 1'b0;
    step();
    if (!s.holdStart) start = 1'b0;
    checkOutput("addr_after_start", debug_address, 0);
    checkOutput("busy_after_start", busy, 1);

    sent      = 0;
    countdown = 0;
    lastDone  = -10;
    seenDone  = 1'b0;
    aborted   = 1'b0;
    prevAddr  = debug_address;
    limit     = TOTAL_BYTES * 10 + 50;

    for (int k = 0; k < limit && !seenDone && !aborted; k++) begin
      step();
      tx_done = 1'b0;
      if (tx_start) begin
        if (sent == 0) checkOutput("first_strobe_latency", cyc - startCyc, 2);
        else checkOutput("strobe_latency", cyc - lastDone, (sent % 4 == 0 && sent < DATA_BYTES) ? 2 : 1);
        if (sent < TOTAL_BYTES) checkOutput("tx_byte", tx_data, expq[sent]);
        else checkOutput("strobe_count", sent + 1, TOTAL_BYTES);
        if (sent < DATA_BYTES) checkOutput("addr_during_send", debug_address, sent / 4);
        if (sent % 4 == 0 && sent < DATA_BYTES) checkOutput("addr_during_load", prevAddr, sent / 4);
        if (sent == s.probeIdx) checkOutput("probe_byte", tx_data, s.probeByte);
        sent++;
        countdown = (s.gap == 0) ? int'($urandom_range(1, 6)) : s.gap;
        if (s.spurious) tx_done = 1'b1;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          tx_done  = 1'b1;
          lastDone = cyc;
        end
      end
      if (s.spurious && cyc == lastDone + 1) tx_done = 1'b1;

      if (abortAt >= 0 && sent == abortAt + 1 && !tx_start && countdown > 0) begin
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        tx_done = 1'b0;
        start   = 1'b0;
        checkOutput("abort_tx_start", tx_start, 0);
        checkOutput("abort_tx_data", tx_data, 0);
        checkOutput("abort_address", debug_address, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        for (int j = 0; j < 5; j++) begin
          step();
          checkOutput("abort_no_done", done, 0);
          checkOutput("abort_stays_idle", busy, 0);
        end
        aborted = 1'b1;
      end

      if (!aborted && done) begin
        seenDone = 1'b1;
        checkOutput("byte_count_at_done", sent, TOTAL_BYTES);
        checkOutput("done_latency", cyc - lastDone, 1);
        checkOutput("busy_during_done", busy, 1);
        start = 1'b0;
      end
      prevAddr = debug_address;
    end

    if (!aborted) begin
      checkOutput("done_seen", seenDone, 1);
      for (int j = 0; j < 3; j++) begin
        step();
        tx_done = 1'b0;
        checkOutput("busy_after_dump", busy, 0);
        checkOutput("no_strobe_after_dump", tx_start, 0);
        checkOutput("no_done_after_dump", done, 0);
      end
      checkOutput("addr_hold_idle", debug_address, SIZE_MEM_DATA - 1);
      checkOutput("tx_data_hold_idle", tx_data, expq[TOTAL_BYTES-1]);
    end
  endtask

  initial begin
    scen_t tbl[5];
    scen_t abortRun;

    tbl[0] = '{0, 3, 1'b0, 1'b0,  8, 8'hEF};
    tbl[1] = '{0, 3, 1'b1, 1'b1, 11, 8'hDE};
    tbl[2] = '{1, 1, 1'b0, 1'b0,  4, 8'h02};
    tbl[3] = '{2, 0, 1'b0, 1'b0,  3, 8'h11};
    tbl[4] = '{2, 0, 1'b1, 1'b1,  0, 8'h44};
    abortRun = '{0, 3, 1'b0, 1'b0, 9, 8'hBE};

    reset   = 1'b1;
    start   = 1'b0;
    tx_done = 1'b0;
    fillMem(0);
    step();
    step();
    checkOutput("reset_address", debug_address, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_tx_start", tx_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    reset = 1'b0;
    step();

    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checkOutput("idle_ignores_tx_done", busy, 0);
    checkOutput("idle_no_strobe", tx_start, 0);

    for (int i = 0; i < 5; i++) begin
      fillMem(tbl[i].pattern);
      applyStimulus(tbl[i], -1);
      step();
    end

    fillMem(1);
    applyStimulus(tbl[2], -1);
`ifdef DUMP_CHECKSUM_EN
    checkOutput("checksum_byte", tx_data, 8'h10);
`else
    checkOutput("last_byte_no_checksum", tx_data, 8'h00);
`endif

    fillMem(0);
    applyStimulus(abortRun, 20);
    applyStimulus(tbl[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_mem_dumper.md
Name: debug_mem_dumper

Overview:
- Debug-side reader for the data memory's debug read port.
- On a start pulse it walks every data-memory word from 0 to SIZE_MEM_DATA-1, drives the debug address, and latches the returned word.
- Each word goes out as 4 bytes, least-significant first, through a UART transmitter start/done handshake.
- Sits between the data memory and the debug-unit UART TX.

Parameters:
- BITS_SIZE, 32, width of the debug address and data words.
- SIZE_MEM_DATA, 16, number of words to dump (word-indexed, addresses 0..SIZE_MEM_DATA-1).
- BITS_BYTE, 8, width of the TX data byte.

Ports:
- i_clk  input  1  single clock, all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- o_debug_address  output  BITS_SIZE  word index driven to the memory debug read port.
- i_debug_data  input  BITS_SIZE  word returned by the memory debug port (combinational to the address).
- o_tx_data  output  BITS_BYTE  byte presented to the UART TX.
- o_tx_start  output  1  one-cycle strobe; o_tx_data is valid while high.
- i_tx_done  input  1  one-cycle pulse from the UART TX when the byte has been sent.
- o_busy  output  1  high from leaving IDLE until returning to IDLE.
- o_done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: synchronous, active-high, takes effect at the next rising edge.
  - State goes to IDLE.
  - o_debug_address, o_tx_data, o_tx_start, o_busy and o_done are all 0.
  - Word shift register, byte index and checksum are cleared.
  - Reset mid-dump aborts immediately; there is no partial completion and no o_done.
- States: IDLE, LOAD, SEND, WAIT_TX, CHK (macro only), DONE.
- IDLE:
  - On i_start=1: address <= 0, byte_idx <= 0, go to LOAD.
- LOAD (address stable this cycle):
  - word_sr <= i_debug_data, go to SEND.
- SEND:
  - o_tx_start=1 and o_tx_data=word_sr[7:0] for exactly this one cycle.
  - Go to WAIT_TX.
- WAIT_TX (hold o_tx_data; o_tx_start=0):
  - On i_tx_done:
    - byte_idx<3: shift word_sr right by 8, byte_idx++, go to SEND.
    - byte_idx==3 and address<SIZE_MEM_DATA-1: address++, byte_idx <= 0, go to LOAD.
    - byte_idx==3 and address==SIZE_MEM_DATA-1: go to CHK (macro) or DONE.
- DONE:
  - o_done=1 for one cycle, go to IDLE. o_busy is still high during DONE.
- Latency:
  - i_start high in cycle N gives o_debug_address=0 in N+1 and o_tx_start in N+2.
  - i_tx_done in cycle M gives the next o_tx_start in M+1 (same word) or M+2 (new word).
- Ignored inputs:
  - i_start outside IDLE is ignored.
  - i_tx_done outside WAIT_TX is ignored.
  - i_start and i_tx_done together in WAIT_TX: only the done is acted on.
- Address width rules:
  - Address is a counter zero-extended to BITS_SIZE.
  - Address never exceeds SIZE_MEM_DATA-1 and does not wrap.
- Output hold:
  - o_debug_address holds its last value in IDLE until the next start.
  - o_tx_data holds its last value when idle.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every transmitted data byte is kept and cleared on start.
  - After the last data byte's i_tx_done, go to CHK.
  - CHK sends the checksum byte with the same SEND/WAIT_TX handshake, then goes to DONE.
  - Total bytes sent = 4*SIZE_MEM_DATA+1.
- Undefined:
  - No checksum register and no CHK state.
  - Exactly 4*SIZE_MEM_DATA bytes are sent.

Decomposition:
- Package mem_dump_pkg holds:
  - the FSM state enum;
  - BYTES_PER_WORD=4;
  - the BITS_BYTE default;
  - the checksum width constant.
- One natural sub-module, dump_byte_serializer:
  - loads a word, presents the low byte, shifts on advance, and flags the last byte.
  - The top-level FSM owns addressing, handshake and checksum.

Test Plan:
- Memory model mem[i]=i, SIZE_MEM_DATA=16, TX responder pulses i_tx_done 3 cycles after each o_tx_start, i_start pulsed -> 64 bytes 00 00 00 00 01 00 00 00 … 0F 00 00 00 in order; o_done one cycle after the final i_tx_done (no macro); o_busy low afterwards.
- mem[2]=0xDEADBEEF -> bytes 8..11 are EF BE AD DE; o_debug_address=2 during the LOAD preceding byte 8.
- i_start held high during the whole dump and i_tx_done pulsed in LOAD/SEND cycles -> no restart, no skipped or duplicated byte, still exactly 64 o_tx_start pulses.
- i_reset asserted in WAIT_TX of byte 20 -> next cycle all outputs 0, state IDLE, no o_done; new i_start -> dump restarts at address 0 with byte 00.
- DUMP_CHECKSUM_EN defined, mem[i]=i+1 -> 65th byte equals 0x10 (XOR of 1..16), then o_done; without the macro, no 65th o_tx_start.
- Latency check: i_start in cycle N -> o_debug_address=0 in N+1, o_tx_start=1 with o_tx_data=0x00 in N+2; i_tx_done at last byte of a word in cycle M -> next o_tx_start in M+2.
